// File: rtl/dco_matrix_pkg.sv
// Shared constants and types for the DCO matrix decoder: field layout of the
// 64-bit control word and the 16-bit thermometer type.
package dco_matrix_pkg;
  localparam int N_ROWS = 16;
  localparam int N_COLS = 16;
  localparam int CODE_W = 8;

  localparam int ROW_P_LSB   = 48;
  localparam int ROW_N_LSB   = 32;
  localparam int COL_ON_LSB  = 16;
  localparam int COL_OFF_LSB = 0;

  typedef logic [15:0] therm16_t;

  // decode(0): only column 0 enabled, no rows lit
  localparam logic [63:0] MTRX_RST = 64'h0000_0000_0001_FFFE;

  function automatic therm16_t bitrev16(input therm16_t v);
    therm16_t r;
    for (int k = 0; k < 16; k++) r[k] = v[15-k];
    return r;
  endfunction
endpackage

// File: rtl/therm16_enc.sv
// 4-bit to 16-bit thermometer encoder. INCL=1 lights value+1 cells so a
// column index always enables at least column 0.
module therm16_enc
  import dco_matrix_pkg::*;
#(
  parameter bit INCL = 1'b0
) (
  input  logic [3:0] val_i,
  output therm16_t   low_o,
  output therm16_t   top_o
);
  logic [4:0] ones;
  assign ones = {1'b0, val_i} + {4'b0, INCL};

  for (genvar k = 0; k < 16; k++) begin : g_bit
    assign low_o[k] = (5'(k) < ones);
  end

  assign top_o = bitrev16(low_o);
endmodule

// File: rtl/dco_matrix_decoder.sv
// Registered 8-bit code to 16x16 snake-order DCO matrix decoder. Even columns
// fill rows bottom-up on row_p, odd columns fill top-down on row_n.
module dco_matrix_decoder
  import dco_matrix_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_mtrx,
  output logic [63:0] mtrx_thrm
);
  logic [3:0]  col_idx, row_cnt;
  therm16_t    row_low, row_top, col_on, col_rev;
  therm16_t    row_p, row_n;
  logic [63:0] mtrx_d, mtrx_q;

  assign col_idx = s_mtrx[7:4];
  assign row_cnt = s_mtrx[3:0];

  therm16_enc #(.INCL(1'b0)) u_row_enc (
    .val_i (row_cnt),
    .low_o (row_low),
    .top_o (row_top)
  );

  therm16_enc #(.INCL(1'b1)) u_col_enc (
    .val_i (col_idx),
    .low_o (col_on),
    .top_o (col_rev)
  );

  // The column encoder's reversed output is not needed for decode; it must
  // still mirror col_on, which guards the shared encoder's reversal path.
  always_comb assert (col_rev == bitrev16(col_on));

  always_comb begin
    row_p = col_idx[0] ? '0      : row_low;
    row_n = col_idx[0] ? row_top : '0;
    mtrx_d = '0;
    mtrx_d[ROW_P_LSB   +: N_ROWS] = row_p;
    mtrx_d[ROW_N_LSB   +: N_ROWS] = row_n;
    mtrx_d[COL_ON_LSB  +: N_COLS] = col_on;
    mtrx_d[COL_OFF_LSB +: N_COLS] = ~col_on;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mtrx_q <= MTRX_RST;
    else     mtrx_q <= mtrx_d;
  end

  assign mtrx_thrm = mtrx_q;
endmodule

// File: tb/tb_dco_matrix_decoder.sv
// Directed bench for dco_matrix_decoder: reset, snake decode, column
// boundaries, latency and a full re-encode sweep.
module tb_dco_matrix_decoder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_mtrx = 8'h00;
  logic [63:0] mtrx_thrm;
  int n_chk = 0;
  int n_fail = 0;

  localparam logic [63:0] RST_V = 64'h0000_0000_0001_FFFE;

  dco_matrix_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .s_mtrx    (s_mtrx),
    .mtrx_thrm (mtrx_thrm)
  );

  always #5 clk = ~clk;

  task automatic step(input logic [7:0] n);
    s_mtrx = n;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_mtrx = 8'hAB;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (mtrx_thrm !== RST_V) begin
      n_fail++; $display("FAIL reset_hold: got %h want %h", mtrx_thrm, RST_V);
    end
    @(negedge clk);
    rst = 1'b0;
    s_mtrx = 8'h13;
    #1;
    n_chk++;
    if (mtrx_thrm !== RST_V) begin
      n_fail++; $display("FAIL reset_release_pre_edge: got %h want %h", mtrx_thrm, RST_V);
    end
    @(posedge clk);
    #1;
    n_chk++;
    if (mtrx_thrm !== 64'h0000_E000_0003_FFFC) begin
      n_fail++; $display("FAIL reset_first_load: got %h want %h", mtrx_thrm, 64'h0000_E000_0003_FFFC);
    end
    #2;
    rst = 1'b1;
    #1;
    n_chk++;
    if (mtrx_thrm !== RST_V) begin
      n_fail++; $display("FAIL reset_async: got %h want %h", mtrx_thrm, RST_V);
    end
    @(posedge clk);
    #1;
    n_chk++;
    if (mtrx_thrm !== RST_V) begin
      n_fail++; $display("FAIL reset_over_edge: got %h want %h", mtrx_thrm, RST_V);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_low_codes();
    logic [7:0]  codes [2] = '{8'd1, 8'd15};
    logic [63:0] exp   [2] = '{64'h0001_0000_0001_FFFE, 64'h7FFF_0000_0001_FFFE};
    for (int i = 0; i < 2; i++) begin
      step(codes[i]);
      n_chk++;
      if (mtrx_thrm !== exp[i]) begin
        n_fail++; $display("FAIL low_code N=%0d: got %h want %h", codes[i], mtrx_thrm, exp[i]);
      end
    end
  endtask

  task automatic test_odd_snake();
    logic [7:0]  codes [3] = '{8'd19, 8'd120, 8'd123};
    logic [63:0] exp   [3] = '{64'h0000_E000_0003_FFFC,
                               64'h0000_FF00_00FF_FF00,
                               64'h0000_FFE0_00FF_FF00};
    for (int i = 0; i < 3; i++) begin
      step(codes[i]);
      n_chk++;
      if (mtrx_thrm !== exp[i]) begin
        n_fail++; $display("FAIL odd_snake N=%0d: got %h want %h", codes[i], mtrx_thrm, exp[i]);
      end
    end
  endtask

  task automatic test_boundaries();
    logic [7:0]  codes [8] = '{8'd15, 8'd16, 8'd31, 8'd32, 8'd33, 8'd250, 8'd255, 8'd0};
    logic [63:0] exp   [8] = '{64'h7FFF_0000_0001_FFFE,
                               64'h0000_0000_0003_FFFC,
                               64'h0000_FFFE_0003_FFFC,
                               64'h0000_0000_0007_FFF8,
                               64'h0001_0000_0007_FFF8,
                               64'h0000_FFC0_FFFF_0000,
                               64'h0000_FFFE_FFFF_0000,
                               64'h0000_0000_0001_FFFE};
    for (int i = 0; i < 8; i++) begin
      step(codes[i]);
      n_chk++;
      if (mtrx_thrm !== exp[i]) begin
        n_fail++; $display("FAIL boundary N=%0d: got %h want %h", codes[i], mtrx_thrm, exp[i]);
      end
    end
  endtask

  task automatic test_latency();
    step(8'd33);
    @(negedge clk);
    s_mtrx = 8'd120;
    #1;
    n_chk++;
    if (mtrx_thrm !== 64'h0001_0000_0007_FFF8) begin
      n_fail++; $display("FAIL latency_hold: got %h want %h", mtrx_thrm, 64'h0001_0000_0007_FFF8);
    end
    @(posedge clk);
    #1;
    n_chk++;
    if (mtrx_thrm !== 64'h0000_FF00_00FF_FF00) begin
      n_fail++; $display("FAIL latency_update: got %h want %h", mtrx_thrm, 64'h0000_FF00_00FF_FF00);
    end
    for (int i = 0; i < 3; i++) begin
      step(8'd33);
      n_chk++;
      if (mtrx_thrm !== 64'h0001_0000_0007_FFF8) begin
        n_fail++; $display("FAIL latency_stable[%0d]: got %h want %h", i, mtrx_thrm, 64'h0001_0000_0007_FFF8);
      end
    end
  endtask

  task automatic test_sweep();
    logic [15:0] rp, rn, co, cf;
    int c, r, hz, got;
    for (int n = 0; n < 256; n++) begin
      step(8'(n));
      {rp, rn, co, cf} = mtrx_thrm;
      c = -1;
      for (int k = 0; k < 16; k++) if (co[k]) c = k;
      r = 0;
      if ((c % 2) == 0) begin
        for (int k = 0; k < 16; k++) if (rp[k]) r = k + 1;
      end else begin
        hz = -1;
        for (int k = 0; k < 16; k++) if (!rn[k]) hz = k;
        r = 15 - hz;
      end
      got = 16 * c + r;
      n_chk++;
      if (got != n) begin
        n_fail++; $display("FAIL sweep_reencode N=%0d: got %0d (word %h) want %0d", n, got, mtrx_thrm, n);
      end
      n_chk++;
      if (cf !== ~co) begin
        n_fail++; $display("FAIL sweep_col_off N=%0d: got %h want %h", n, cf, ~co);
      end
    end
  endtask

  initial begin
    test_reset();
    test_low_codes();
    test_odd_snake();
    test_boundaries();
    test_latency();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dco_matrix_decoder.md
Name: dco_matrix_decoder

Overview:
- Registered binary-to-matrix decoder for a 256-unit DCO capacitor/current-cell array.
- The array is organised as 16 columns × 16 rows.
- It converts an 8-bit control word into four 16-bit thermometer control buses (row_p, row_n, col_on, col_off).
- Rows are filled in a snake pattern: even columns fill bottom-up via row_p, odd columns fill top-down via row_n.
- Sits between the loop-filter/DCO control word and the DCO matrix driver.

Parameters:
- None. Widths are fixed: 8-bit code, 16 rows, 16 columns, 64-bit output.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- s_mtrx  input  8  binary DCO code N (0..255)
- mtrx_thrm  output  64  packed matrix control:
  - [63:48] row_p
  - [47:32] row_n
  - [31:16] col_on
  - [15:0] col_off

Behaviour:
- One clock, clk; reset rst is asynchronous and active-high.
- Decode fields: C = N[7:4] (active column), R = N[3:0] (rows lit in active column).
- col_on[k] = 1 for k <= C, else 0. Thermometer from bit 0; bit 0 is always set.
- col_off = ~col_on (bitwise complement, always).
- C even:
  - row_p = (1<<R)-1, i.e. R lowest bits set; 0000 when R = 0.
  - row_n = 16'h0000.
- C odd:
  - row_n = R highest bits set, i.e. bits 15 down to 16-R; 0000 when R = 0.
  - row_p = 16'h0000.
- Inverse property, which the verifier's reference encoder relies on. With c = highest set index of col_on:
  - N = 16*c + (highest set index of row_p, plus 1, or 0 if none) when c is even.
  - N = 16*c + (15 − highest index where row_n is 0) when c is odd.
- Latency: purely combinational decode, with all 64 output bits registered on the rising edge of clk.
  - mtrx_thrm reflects the s_mtrx sampled at the most recent rising edge.
  - Latency is 1 cycle; no input register.
  - Outputs are glitch-free between edges.
- Reset: while rst = 1, mtrx_thrm is asynchronously forced to decode(0):
  - row_p = 0000, row_n = 0000, col_on = 0001, col_off = FFFE.
  - The first edge after rst deasserts loads decode(s_mtrx).
- Reset asserted mid-operation overrides immediately, independent of clk.
- No handshake, no state machine; a new code is accepted every cycle.
- Boundaries:
  - N = 0 → col_on 0001.
  - N = 255 → col_on FFFF, col_off 0000, row_n FFFE.
  - Column crossings, e.g. 15→16: row_p 7FFF → row_n 0000, col_on 0001 → 0003.
- All 256 codes are legal; no X/undefined outputs.

Decomposition:
- Package dco_matrix_pkg holds:
  - constants N_ROWS = 16, N_COLS = 16, CODE_W = 8.
  - field offsets ROW_P_LSB = 48, ROW_N_LSB = 32, COL_ON_LSB = 16, COL_OFF_LSB = 0.
  - typedef logic [15:0] therm16_t.
- One sub-module: therm16_enc.
  - Input: 4-bit value.
  - Outputs: 16-bit low-justified thermometer (count of ones = value) and its bit-reversed top-justified form.
  - Instantiated for R (rows, including R = 0 → zero).
  - Reused with an inclusive variant, ones = value+1, for col_on.
- Top level muxes row_p/row_n on C[0] and holds the 64-bit register.

Test Plan:
1. Reset: assert rst asynchronously between edges → mtrx_thrm immediately = 0000_0000_0001_FFFE (row_p, row_n, col_on, col_off); held until rst deasserts.
2. Low codes: N = 1 → row_p 0001, row_n 0000, col_on 0001, col_off FFFE. N = 15 → row_p 7FFF.
3. Odd-column snake:
   - N = 19 (0x13) → col_on 0003, col_off FFFC, row_n E000, row_p 0000.
   - N = 120 → col_on 00FF, row_n FF00.
   - N = 123 → row_n FFE0.
4. Column boundaries:
   - N = 16 → col_on 0003, row_n 0000.
   - N = 31 → row_n FFFE.
   - N = 32 → col_on 0007, row_p 0000.
   - N = 33 → row_p 0001.
   - N = 250 → col_on FFFF, col_off 0000, row_n FFC0.
5. Latency: change s_mtrx between edges → mtrx_thrm unchanged until the next rising edge, then equals the new decode. Holding the same code (33, 33, 33) gives stable output.
6. Exhaustive sweep 0..255 with the reference encoder from Behaviour → re-encoded value equals N for every code, and col_off == ~col_on every cycle.
